// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Arbitrates the single-port program/data RAM between two requesters.
// Port A (CPU fetch/data) has default priority. Port B (loader/debug) has
// starvation protection and can lock the RAM for a burst. The grant, address
// and write-data paths are combinational. Read data comes back to the winner
// one cycle after its grant.

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_WAIT   = 4   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  reset,

  // Port A: CPU fetch/data
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,

  // Port B: program loader/debug
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic                  b_lock,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  lock_active,

  // RAM side
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Forced-grant threshold, sized to match the 4-bit starvation counter.
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       b_forced;

  assign b_forced = (starve_cnt == MAX_WAIT_C);

  // Grant decision: B owns the RAM while locked, otherwise A wins unless B
  // has waited MAX_WAIT consecutive cycles.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state == LOCKED) begin
      b_gnt = b_req;
    end else begin
      b_gnt = b_req && (!a_req || b_forced);
      a_gnt = a_req && !b_gnt;
    end
  end

  // RAM drive: mux the winner's address, data and write enable; park at zero
  // when nobody is granted.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (b_gnt) begin
      ram_addr = b_addr;
      ram_din  = b_wdata;
      ram_we   = b_we;
    end else if (a_gnt) begin
      ram_addr = a_addr;
      ram_din  = a_wdata;
      ram_we   = a_we;
    end
  end

  // Lock FSM with registered lock_active, plus the B starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lock_active <= 1'b0;
      starve_cnt  <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (b_gnt && b_lock) begin
            state       <= LOCKED;
            lock_active <= 1'b1;
          end
        end
        LOCKED: begin
          if (!b_lock || !b_req) begin
            state       <= IDLE;
            lock_active <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          lock_active <= 1'b0;
        end
      endcase

      // Count consecutive denied B cycles; a grant or a dropped request
      // clears it, and the counter sits at zero for the whole lock.
      if (state == LOCKED) begin
        starve_cnt <= 4'd0;
      end else if (b_req && !b_gnt) begin
        if (!b_forced) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  // Read return: capture RAM data at the end of a granted read and pulse
  // rvalid for the following cycle; rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the returned-data registers are reset too, so a read that was
      // in flight at reset is discarded rather than surfacing afterwards.
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= ram_dout;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= ram_dout;
      end
    end
  end

endmodule
